// File: rtl/vga_crtc_timing.sv
// vga_crtc_timing: raster timing generator feeding the text-mode pixel stage.
//
// Produces a pixel clock enable, horizontal/vertical counters, undelayed
// horizontal sync/active decodes, vertical sync/active decodes delayed by
// PIPE_DLY enable ticks (to line up with the text stage's own pipeline),
// an undelayed vertical-retrace status bit and a one-clk frame_start pulse.
//
// Optional feature macro: VGA_CRTC_TIMING_VIRQ_EN adds a sticky vertical
// retrace interrupt (vretrace_irq) cleared by irq_ack.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   irq_ack       in   interrupt acknowledge (VGA_CRTC_TIMING_VIRQ_EN only)
//   vretrace_irq  out  sticky retrace interrupt (VGA_CRTC_TIMING_VIRQ_EN only)
//   enable_o      out  pixel enable, one clk in every CLK_DIV clks
//   h_count       out  horizontal pixel counter
//   v_count       out  line counter
//   horiz_sync_o  out  horizontal sync, undelayed
//   video_on_h_o  out  horizontal active region, undelayed
//   vert_sync_o   out  vertical sync, delayed PIPE_DLY enable ticks
//   video_on_v_o  out  vertical active region, delayed PIPE_DLY enable ticks
//   vretrace_o    out  vertical retrace status, undelayed
//   frame_start   out  one-clk pulse on the enable tick at (h=0, v=0)

module vga_crtc_timing #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 400,
    parameter int unsigned V_FP      = 12,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 35,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned PIPE_DLY  = 8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_CRTC_TIMING_VIRQ_EN
    input  logic       irq_ack,
    output logic       vretrace_irq,
`endif
    output logic       enable_o,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       horiz_sync_o,
    output logic       video_on_h_o,
    output logic       vert_sync_o,
    output logic       video_on_v_o,
    output logic       vretrace_o,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Thresholds are 11 bits so a full 1024-wide visible region still compares correctly.
    localparam logic [10:0] H_VIS_L  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_VIS_L  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_crtc_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
        $error("vga_crtc_timing: CLK_DIV must be in 1..16");
    end
    if (PIPE_DLY < 1) begin : g_dly_chk
        $error("vga_crtc_timing: PIPE_DLY must be at least 1");
    end

    logic [3:0]          div_q, div_d;
    logic                enable_d;
    logic [9:0]          h_d, v_d;
    logic                hsync_d, vis_h_d, vretrace_d, frame_start_d;
    logic                vs_in, vo_in;
    logic [PIPE_DLY-1:0] vs_sr_q, vs_sr_d;
    logic [PIPE_DLY-1:0] vo_sr_q, vo_sr_d;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        // enable_o is high while the divider sits at its last value.
        enable_d = (div_d == DIV_LAST);

        h_d = h_count;
        v_d = v_count;
        if (enable_o) begin
            if (h_count == H_LAST) begin
                h_d = '0;
                v_d = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
            end else begin
                h_d = h_count + 10'd1;
            end
        end

        // Decodes use next-state counts so the registered outputs line up with the counts.
        vis_h_d       = ({1'b0, h_d} < H_VIS_L);
        hsync_d       = ({1'b0, h_d} >= HS_FIRST && {1'b0, h_d} <= HS_LAST) ?
                        HSYNC_POL : ~HSYNC_POL;
        vretrace_d    = ({1'b0, v_d} >= VS_FIRST && {1'b0, v_d} <= VS_LAST);
        frame_start_d = enable_d && (h_d == 10'd0) && (v_d == 10'd0);

        // Delay-line inputs describe the current (registered) line.
        vs_in   = vretrace_o ? VSYNC_POL : ~VSYNC_POL;
        vo_in   = ({1'b0, v_count} < V_VIS_L);
        vs_sr_d = vs_sr_q;
        vo_sr_d = vo_sr_q;
        if (enable_o) begin
            vs_sr_d = PIPE_DLY'({vs_sr_q, vs_in});
            vo_sr_d = PIPE_DLY'({vo_sr_q, vo_in});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            enable_o     <= 1'b0;
            h_count      <= '0;
            v_count      <= '0;
            video_on_h_o <= 1'b1;
            horiz_sync_o <= ~HSYNC_POL;
            vretrace_o   <= 1'b0;
            frame_start  <= 1'b0;
            vs_sr_q      <= {PIPE_DLY{~VSYNC_POL}};
            vo_sr_q      <= '0;
        end else begin
            div_q        <= div_d;
            enable_o     <= enable_d;
            h_count      <= h_d;
            v_count      <= v_d;
            video_on_h_o <= vis_h_d;
            horiz_sync_o <= hsync_d;
            vretrace_o   <= vretrace_d;
            frame_start  <= frame_start_d;
            vs_sr_q      <= vs_sr_d;
            vo_sr_q      <= vo_sr_d;
        end
    end

    assign vert_sync_o  = vs_sr_q[PIPE_DLY-1];
    assign video_on_v_o = vo_sr_q[PIPE_DLY-1];

`ifdef VGA_CRTC_TIMING_VIRQ_EN
    logic vretrace_prev_q;
    logic irq_q, irq_d;

    // Set on the clk after vretrace_o rises; a simultaneous ack loses to the set.
    always_comb begin
        irq_d = irq_q;
        if (vretrace_o && !vretrace_prev_q) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vretrace_prev_q <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            vretrace_prev_q <= vretrace_o;
            irq_q           <= irq_d;
        end
    end

    assign vretrace_irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_crtc_timing.sv
// Bench for vga_crtc_timing: two instances (CLK_DIV=2 and CLK_DIV=1) with the
// default horizontal timing and a shortened vertical frame, compared every clk
// against an arithmetic model of position-versus-elapsed-clocks.

module tb_vga_crtc_timing;

    localparam int unsigned HV = 640;
    localparam int unsigned HF = 16;
    localparam int unsigned HS = 96;
    localparam int unsigned HB = 48;
    localparam int unsigned VV = 10;
    localparam int unsigned VF = 2;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 3;
    localparam int unsigned PD = 8;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;

    logic clk, rst, irq_ack;

    logic       a_en, a_hs, a_voh, a_vs, a_vov, a_vr, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_en, b_hs, b_voh, b_vs, b_vov, b_vr, b_fs;
    logic [9:0] b_h, b_v;
`ifdef VGA_CRTC_TIMING_VIRQ_EN
    logic       a_irq, b_irq;
`endif

    vga_crtc_timing #(
        .CLK_DIV(2), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIPE_DLY(PD)
    ) u_dut_a (
        .clk(clk),
        .rst(rst),
`ifdef VGA_CRTC_TIMING_VIRQ_EN
        .irq_ack(irq_ack),
        .vretrace_irq(a_irq),
`endif
        .enable_o(a_en),
        .h_count(a_h),
        .v_count(a_v),
        .horiz_sync_o(a_hs),
        .video_on_h_o(a_voh),
        .vert_sync_o(a_vs),
        .video_on_v_o(a_vov),
        .vretrace_o(a_vr),
        .frame_start(a_fs)
    );

    vga_crtc_timing #(
        .CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIPE_DLY(PD)
    ) u_dut_b (
        .clk(clk),
        .rst(rst),
`ifdef VGA_CRTC_TIMING_VIRQ_EN
        .irq_ack(irq_ack),
        .vretrace_irq(b_irq),
`endif
        .enable_o(b_en),
        .h_count(b_h),
        .v_count(b_v),
        .horiz_sync_o(b_hs),
        .video_on_h_o(b_voh),
        .vert_sync_o(b_vs),
        .video_on_v_o(b_vov),
        .vretrace_o(b_vr),
        .frame_start(b_fs)
    );

    logic [26:0] obs_a, obs_b;
    assign obs_a = {a_en, a_h, a_v, a_hs, a_voh, a_vs, a_vov, a_vr, a_fs};
    assign obs_b = {b_en, b_h, b_v, b_hs, b_voh, b_vs, b_vov, b_vr, b_fs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors, miscompares;
    int         edges, cyc;
    logic       irq_a_exp, irq_b_exp;
    int         fs_a_last, fs_b_last, wrap_a_last;
    int         hs_low_a, vis_a;
    logic [9:0] prev_a_h;
    logic       prev_a_vs, prev_b_vs;

    // Expected outputs after n rising edges since reset release, for divider d.
    function automatic logic [26:0] model_vec(input int n, input int unsigned d);
        int unsigned t, p, h, v, pv;
        logic en, hs, voh, vs, vov, vr, fs;
        if (n == 0) t = 0;
        else if (d == 1) t = n - 1;
        else t = n / d;
        en  = (n != 0) && ((n % d) == d - 1);
        p   = t % (HT * VT);
        h   = p % HT;
        v   = p / HT;
        voh = (h < HV);
        hs  = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
        vr  = (v >= VV + VF && v < VV + VF + VS);
        if (t >= PD) begin
            pv  = ((t - PD) % (HT * VT)) / HT;
            vs  = (pv >= VV + VF && pv < VV + VF + VS);
            vov = (pv < VV);
        end else begin
            vs  = 1'b0;
            vov = 1'b0;
        end
        fs = en && (h == 0) && (v == 0);
        return {en, 10'(h), 10'(v), hs, voh, vs, vov, vr, fs};
    endfunction

    function automatic logic vr_at(input int n, input int unsigned d);
        logic [26:0] m;
        m = model_vec(n, d);
        return m[1];
    endfunction

    // True in the clk where retrace status has just risen (interrupt set clk).
    function automatic logic set_cond(input int n, input int unsigned d);
        if (n == 0) return 1'b0;
        return vr_at(n, d) && !vr_at(n - 1, d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_monitors();
        edges       = 0;
        irq_a_exp   = 1'b0;
        irq_b_exp   = 1'b0;
        fs_a_last   = -1;
        fs_b_last   = -1;
        wrap_a_last = -1;
        hs_low_a    = 0;
        vis_a       = 0;
        prev_a_h    = 10'd0;
        prev_a_vs   = 1'b0;
        prev_b_vs   = 1'b0;
    endtask

    // One clk: called at a negedge, returns at the next negedge after checking.
    task automatic tick();
        logic sa, sb;
        sa = set_cond(edges, 2);
        sb = set_cond(edges, 1);
        @(posedge clk);
        edges++;
        cyc++;
        if (sa) irq_a_exp = 1'b1;
        else if (irq_ack) irq_a_exp = 1'b0;
        if (sb) irq_b_exp = 1'b1;
        else if (irq_ack) irq_b_exp = 1'b0;
        @(negedge clk);
        check("vec_a", 32'(obs_a), 32'(model_vec(edges, 2)));
        check("vec_b", 32'(obs_b), 32'(model_vec(edges, 1)));
`ifdef VGA_CRTC_TIMING_VIRQ_EN
        check("irq_a", 32'(a_irq), 32'(irq_a_exp));
        check("irq_b", 32'(b_irq), 32'(irq_b_exp));
        if (sa && irq_ack) check("irq_set_wins_a", 32'(a_irq), 32'd1);
`endif
        if (a_fs) begin
            if (fs_a_last >= 0) check("frame_period_a", 32'(cyc - fs_a_last), 32'(HT * VT * 2));
            fs_a_last = cyc;
        end
        if (b_fs) begin
            if (fs_b_last >= 0) check("frame_period_b", 32'(cyc - fs_b_last), 32'(HT * VT));
            fs_b_last = cyc;
        end
        if (prev_a_h == 10'(HT - 1) && a_h == 10'd0) begin
            if (wrap_a_last >= 0) check("line_period_a", 32'(cyc - wrap_a_last), 32'(HT * 2));
            else check("first_wrap_v_a", 32'(a_v), 32'd1);
            check("hsync_width_a", 32'(hs_low_a), 32'(HS));
            check("hvisible_width_a", 32'(vis_a), 32'(HV));
            wrap_a_last = cyc;
            hs_low_a    = 0;
            vis_a       = 0;
        end
        if (a_en) begin
            if (!a_hs) hs_low_a++;
            if (a_voh) vis_a++;
        end
        prev_a_h = a_h;
        if (a_vs && !prev_a_vs) check("vsync_rise_a", 32'({a_v, a_h}), 32'({10'(VV + VF), 10'(PD)}));
        if (!a_vs && prev_a_vs) check("vsync_fall_a", 32'({a_v, a_h}),
                                      32'({10'(VV + VF + VS), 10'(PD)}));
        if (b_vs && !prev_b_vs) check("vsync_rise_b", 32'({b_v, b_h}), 32'({10'(VV + VF), 10'(PD)}));
        if (!b_vs && prev_b_vs) check("vsync_fall_b", 32'({b_v, b_h}),
                                      32'({10'(VV + VF + VS), 10'(PD)}));
        prev_a_vs = a_vs;
        prev_b_vs = b_vs;
    endtask

    task automatic run(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            // Ack is forced on instance A's interrupt set clk to exercise set-wins.
            irq_ack = ($urandom_range(0, 31) == 0) || set_cond(edges, 2);
            tick();
        end
    endtask

    // Assert reset between clock edges and check it acts before the next edge.
    task automatic async_reset(input int unsigned offset);
        irq_ack = 1'b0;
        @(posedge clk);
        #(offset);
        rst = 1'b1;
        #1;
        check("rst_async_a", 32'(obs_a), 32'(model_vec(0, 2)));
        check("rst_async_b", 32'(obs_b), 32'(model_vec(0, 1)));
`ifdef VGA_CRTC_TIMING_VIRQ_EN
        check("rst_async_irq_a", 32'(a_irq), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_monitors();
        check("rst_release_a", 32'(obs_a), 32'(model_vec(0, 2)));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        irq_ack     = 1'b0;
        rst         = 1'b1;
        reset_monitors();
        repeat (3) @(negedge clk);
        check("rst_init_a", 32'(obs_a), 32'(model_vec(0, 2)));
        check("rst_init_b", 32'(obs_b), 32'(model_vec(0, 1)));
        rst = 1'b0;

        run($urandom_range(500, 3000));
        async_reset($urandom_range(1, 3));
        run($urandom_range(200, 2000));
        async_reset($urandom_range(1, 3));
        // Two full frames of instance A plus margin.
        run(2 * HT * VT * 2 + 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
